// File: rtl/pio_regtbl_pkg.sv
// Shared types, address decode and width helpers for the pio_regtbl PIO slave.
package pio_regtbl_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_WAIT
    } state_e;

    typedef enum logic [1:0] {
        RGN_TBL,
        RGN_REG,
        RGN_UNMAPPED
    } region_e;

    // Read-wait counter holds RD_LAT-1, so 3 bits cover RD_LAT up to 8.
    localparam int unsigned LAT_CNT_W  = 3;
    localparam int unsigned MAX_ADDR_W = 32;

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic region_e decode(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           tbl_depth,
        input int unsigned           reg_base,
        input int unsigned           num_regs
    );
        if (addr < tbl_depth) begin
            return RGN_TBL;
        end
        if ((addr >= reg_base) && (addr < (reg_base + num_regs))) begin
            return RGN_REG;
        end
        return RGN_UNMAPPED;
    endfunction

endpackage

// File: rtl/pio_regtbl_ram.sv
// Table storage with an RD_LAT-deep read pipeline; PIO_REGTBL_PARITY_EN adds a
// per-entry even-parity bit that flags corrupted table reads.
module pio_regtbl_ram
    import pio_regtbl_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TBL_DEPTH = 1024,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [idx_w(TBL_DEPTH)-1:0]  wr_idx,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         rd_en,
    input  logic                         rd_tbl,
    input  logic [idx_w(TBL_DEPTH)-1:0]  rd_idx,
    input  logic [DATA_W-1:0]            alt_data,
    input  logic                         alt_err,
    output logic                         rd_vld,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_err
);

    logic [DATA_W-1:0] mem [TBL_DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              par_bad;

    logic              vld_q [RD_LAT];
    logic              err_q [RD_LAT];
    logic [DATA_W-1:0] dat_q [RD_LAT];

    assign rd_word = mem[rd_idx];

`ifdef PIO_REGTBL_PARITY_EN
    logic par_mem [TBL_DEPTH];

    assign par_bad = par_mem[rd_idx] != (^rd_word);
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
`ifdef PIO_REGTBL_PARITY_EN
            par_mem[wr_idx] <= ^wr_data;
`endif
        end
    end

    // Data/err stages only load behind a valid, so the last stage holds data_r between responses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= 1'b0;
                err_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= rd_en;
            if (rd_en) begin
                dat_q[0] <= rd_tbl ? rd_word : alt_data;
                err_q[0] <= alt_err | (rd_tbl & par_bad);
            end
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                    err_q[i] <= err_q[i-1];
                end
            end
        end
    end

    assign rd_vld  = vld_q[RD_LAT-1];
    assign rd_data = dat_q[RD_LAT-1];
    assign rd_err  = err_q[RD_LAT-1];

endmodule

// File: rtl/pio_regtbl.sv
// PIO leaf slave: NUM_REGS registers plus a TBL_DEPTH-entry table behind a
// ready/valid command port. Optional table parity: PIO_REGTBL_PARITY_EN.
module pio_regtbl
    import pio_regtbl_pkg::*;
#(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        ADDR_W    = 16,
    parameter int unsigned        TBL_DEPTH = 1024,
    parameter int unsigned        NUM_REGS  = 4,
    parameter int unsigned        REG_BASE  = 'h1000,
    parameter int unsigned        RD_LAT    = 2,
    parameter logic [DATA_W-1:0]  ID_VALUE  = 'hB10C_0002
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_w,
    output logic [DATA_W-1:0] data_r,
    output logic              rd_vld,
    output logic              wr_ack,
    output logic              err,
    output logic              init_done
);

    localparam int unsigned TBL_IW = idx_w(TBL_DEPTH);
    localparam int unsigned REG_IW = idx_w(NUM_REGS);

    state_e                state, state_nxt;
    logic [TBL_IW-1:0]     init_ptr;
    logic [LAT_CNT_W-1:0]  lat_cnt;
    logic                  wr_err;
    logic [DATA_W-1:0]     regs [NUM_REGS];

    logic [MAX_ADDR_W-1:0] addr_ext;
    region_e               rgn;
    logic [REG_IW-1:0]     reg_idx;
    logic [TBL_IW-1:0]     tbl_idx;
    logic                  reg_ro;
    logic                  bad_wr;
    logic                  acc_wr, acc_rd;

    logic                  ram_we;
    logic [TBL_IW-1:0]     ram_widx;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     alt_data;
    logic                  rd_err;

    assign addr_ext = MAX_ADDR_W'(addr);
    assign rgn      = decode(addr_ext, TBL_DEPTH, REG_BASE, NUM_REGS);
    assign reg_idx  = REG_IW'(addr_ext - REG_BASE);
    assign tbl_idx  = addr[TBL_IW-1:0];
    assign reg_ro   = (rgn == RGN_REG) && (reg_idx == '0);
    assign bad_wr   = (rgn == RGN_UNMAPPED) || reg_ro;

    assign cmd_rdy  = (state == ST_IDLE);
    assign acc_wr   = cmd_rdy && cmd_vld && rw;
    assign acc_rd   = cmd_rdy && cmd_vld && !rw;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT:    if (init_ptr == TBL_IW'(TBL_DEPTH - 1)) state_nxt = ST_IDLE;
            ST_IDLE:    if (acc_rd) state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (lat_cnt == '0) state_nxt = ST_IDLE;
            default:    state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            init_ptr  <= '0;
            lat_cnt   <= '0;
            init_done <= 1'b0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_ptr <= init_ptr + 1'b1;
            end
            if ((state == ST_INIT) && (state_nxt == ST_IDLE)) begin
                init_done <= 1'b1;
            end
            if (acc_rd) begin
                lat_cnt <= LAT_CNT_W'(RD_LAT - 1);
            end else if ((state == ST_RD_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            wr_ack <= acc_wr;
            wr_err <= acc_wr && bad_wr;
        end
    end

    // regs[0] is never written; reads of register 0 return ID_VALUE instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (acc_wr && (rgn == RGN_REG) && !reg_ro) begin
            regs[reg_idx] <= data_w;
        end
    end

    always_comb begin
        alt_data = '0;
        if (rgn == RGN_REG) begin
            alt_data = (reg_idx == '0) ? ID_VALUE : regs[reg_idx];
        end
    end

    always_comb begin
        ram_we    = acc_wr && (rgn == RGN_TBL);
        ram_widx  = tbl_idx;
        ram_wdata = data_w;
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_widx  = init_ptr;
            ram_wdata = '0;
        end
    end

    pio_regtbl_ram #(
        .DATA_W    (DATA_W),
        .TBL_DEPTH (TBL_DEPTH),
        .RD_LAT    (RD_LAT)
    ) u_ram (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (ram_we),
        .wr_idx   (ram_widx),
        .wr_data  (ram_wdata),
        .rd_en    (acc_rd),
        .rd_tbl   (rgn == RGN_TBL),
        .rd_idx   (tbl_idx),
        .alt_data (alt_data),
        .alt_err  (rgn == RGN_UNMAPPED),
        .rd_vld   (rd_vld),
        .rd_data  (data_r),
        .rd_err   (rd_err)
    );

    assign err = (wr_ack & wr_err) | (rd_vld & rd_err);

endmodule

// File: tb/tb_pio_regtbl.sv
// Directed self-checking bench for pio_regtbl (RD_LAT=2, 1024-entry table, 4 registers at 0x1000).
module tb_pio_regtbl;

    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned TBL_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        rd_vld;
    logic        wr_ack;
    logic        err;
    logic        init_done;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    pio_regtbl #(
        .DATA_W    (32),
        .ADDR_W    (16),
        .TBL_DEPTH (TBL_DEPTH),
        .NUM_REGS  (4),
        .REG_BASE  ('h1000),
        .RD_LAT    (RD_LAT),
        .ID_VALUE  (32'hB10C_0002)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .rw        (rw),
        .addr      (addr),
        .data_w    (data_w),
        .data_r    (data_r),
        .rd_vld    (rd_vld),
        .wr_ack    (wr_ack),
        .err       (err),
        .init_done (init_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a command and wait (bounded) for it to be accepted; returns in cycle k+1.
    task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d, output logic ok);
        int unsigned n;
        n = 0;
        cmd_vld = 1'b1;
        rw      = w;
        addr    = a;
        data_w  = d;
        while ((cmd_rdy !== 1'b1) && (n < 64)) begin
            tick();
            n++;
        end
        ok = (cmd_rdy === 1'b1);
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic collect_rd(output logic [7:0] lat, output logic [31:0] d, output logic e,
                              output logic rdy_seen, output logic rdy_after, output logic vld_after);
        lat      = '0;
        d        = '0;
        e        = 1'b0;
        rdy_seen = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (cmd_rdy !== 1'b0) rdy_seen = 1'b1;
            if (rd_vld === 1'b1) begin
                lat = 8'(c);
                d   = data_r;
                e   = err;
                break;
            end
            tick();
        end
        tick();
        rdy_after = cmd_rdy;
        vld_after = rd_vld;
    endtask

    task automatic do_read(input logic [15:0] a, output logic ok, output logic [7:0] lat,
                           output logic [31:0] d, output logic e, output logic rs,
                           output logic ra, output logic va);
        issue(1'b0, a, 32'h0, ok);
        collect_rd(lat, d, e, rs, ra, va);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, output logic ok,
                            output logic ack, output logic e);
        issue(1'b1, a, d, ok);
        ack = wr_ack;
        e   = err;
    endtask

    task automatic wait_sweep(output int unsigned cnt, output logic early, output logic vld_any);
        cnt     = 0;
        early   = 1'b0;
        vld_any = 1'b0;
        while ((cmd_rdy !== 1'b1) && (cnt < 2000)) begin
            if (init_done !== 1'b0) early = 1'b1;
            if (rd_vld !== 1'b0) vld_any = 1'b1;
            cnt++;
            tick();
        end
    endtask

    task automatic test_reset;
        int unsigned cnt;
        logic early, vany, ok, e, rs, ra, va;
        logic [7:0]  lat;
        logic [31:0] d;
        cmd_vld = 1'b0;
        rw      = 1'b0;
        addr    = '0;
        data_w  = '0;
        reset_n = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({cmd_rdy, rd_vld, wr_ack, err, init_done, data_r} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b vld=%b ack=%b err=%b done=%b data=%h, want all 0",
                     cmd_rdy, rd_vld, wr_ack, err, init_done, data_r);
        end
        reset_n = 1'b1;
        wait_sweep(cnt, early, vany);
        vectors++;
        if ((cnt !== TBL_DEPTH) || (early !== 1'b0) || (init_done !== 1'b1)) begin
            miscompares++;
            $display("FAIL init_sweep: got busy_cycles=%0d early_done=%b done=%b, want %0d 0 1",
                     cnt, early, init_done, TBL_DEPTH);
        end
        do_read(16'h0005, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL tbl5_after_init: got ok=%b lat=%0d data=%h err=%b, want 1 %0d 00000000 0",
                     ok, lat, d, e, RD_LAT);
        end
    endtask

    task automatic test_table;
        logic ok, ack, e, rs, ra, va;
        logic [7:0]  lat;
        logic [31:0] d;
        do_write(16'h03FF, 32'hA5A5_0001, ok, ack, e);
        vectors++;
        if ({ok, ack, e} !== 3'b110) begin
            miscompares++;
            $display("FAIL tbl3ff_wr: got ok=%b ack=%b err=%b, want 1 1 0", ok, ack, e);
        end
        do_write(16'h0000, 32'h1234_5678, ok, ack, e);
        vectors++;
        if ({ok, ack, e} !== 3'b110) begin
            miscompares++;
            $display("FAIL tbl0_wr: got ok=%b ack=%b err=%b, want 1 1 0", ok, ack, e);
        end
        do_read(16'h03FF, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e, rs, ra, va} !== {1'b1, 8'(RD_LAT), 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL tbl3ff_rd: got ok=%b lat=%0d data=%h err=%b rdy_in_wait=%b rdy_after=%b vld_after=%b, want 1 %0d a5a50001 0 0 1 0",
                     ok, lat, d, e, rs, ra, va, RD_LAT);
        end
        do_read(16'h0000, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'h1234_5678, 1'b0}) begin
            miscompares++;
            $display("FAIL tbl0_rd: got ok=%b lat=%0d data=%h err=%b, want 1 %0d 12345678 0",
                     ok, lat, d, e, RD_LAT);
        end
    endtask

    task automatic test_registers;
        logic ok, ack, e, rs, ra, va;
        logic [7:0]  lat;
        logic [31:0] d;
        logic [15:0] wa [3];
        logic [31:0] wd [3];
        wa = '{16'h1001, 16'h1002, 16'h1003};
        wd = '{32'h1111_0001, 32'h2222_0002, 32'hCAFE_F00D};
        do_read(16'h1000, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'hB10C_0002, 1'b0}) begin
            miscompares++;
            $display("FAIL reg0_rd: got ok=%b lat=%0d data=%h err=%b, want 1 %0d b10c0002 0", ok, lat, d, e, RD_LAT);
        end
        do_write(16'h1000, 32'h0000_1234, ok, ack, e);
        vectors++;
        if ({ok, ack, e} !== 3'b111) begin
            miscompares++;
            $display("FAIL reg0_wr_ro: got ok=%b ack=%b err=%b, want 1 1 1", ok, ack, e);
        end
        do_read(16'h1000, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'hB10C_0002, 1'b0}) begin
            miscompares++;
            $display("FAIL reg0_reread: got ok=%b lat=%0d data=%h err=%b, want 1 %0d b10c0002 0", ok, lat, d, e, RD_LAT);
        end
        for (int i = 0; i < 3; i++) begin
            do_write(wa[i], wd[i], ok, ack, e);
            vectors++;
            if ({ok, ack, e} !== 3'b110) begin
                miscompares++;
                $display("FAIL reg_wr[%h]: got ok=%b ack=%b err=%b, want 1 1 0", wa[i], ok, ack, e);
            end
        end
        for (int i = 2; i >= 0; i--) begin
            do_read(wa[i], ok, lat, d, e, rs, ra, va);
            vectors++;
            if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), wd[i], 1'b0}) begin
                miscompares++;
                $display("FAIL reg_rd[%h]: got ok=%b lat=%0d data=%h err=%b, want 1 %0d %h 0",
                         wa[i], ok, lat, d, e, RD_LAT, wd[i]);
            end
        end
    endtask

    task automatic test_unmapped;
        logic ok, ack, e, rs, ra, va;
        logic [7:0]  lat;
        logic [31:0] d;
        logic [15:0] ra_tab [4];
        logic [31:0] rd_tab [4];
        ra_tab = '{16'h1001, 16'h1002, 16'h1003, 16'h0000};
        rd_tab = '{32'h1111_0001, 32'h2222_0002, 32'hCAFE_F00D, 32'h1234_5678};
        do_read(16'h0800, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL unmapped_rd_0800: got ok=%b lat=%0d data=%h err=%b, want 1 %0d 00000000 1", ok, lat, d, e, RD_LAT);
        end
        do_read(16'hFFFF, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'h0, 1'b1}) begin
            miscompares++;
            $display("FAIL unmapped_rd_ffff: got ok=%b lat=%0d data=%h err=%b, want 1 %0d 00000000 1", ok, lat, d, e, RD_LAT);
        end
        do_write(16'h1004, 32'hFFFF_FFFF, ok, ack, e);
        vectors++;
        if ({ok, ack, e} !== 3'b111) begin
            miscompares++;
            $display("FAIL unmapped_wr_1004: got ok=%b ack=%b err=%b, want 1 1 1", ok, ack, e);
        end
        do_write(16'h0400, 32'h5555_5555, ok, ack, e);
        vectors++;
        if ({ok, ack, e} !== 3'b111) begin
            miscompares++;
            $display("FAIL unmapped_wr_0400: got ok=%b ack=%b err=%b, want 1 1 1", ok, ack, e);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(ra_tab[i], ok, lat, d, e, rs, ra, va);
            vectors++;
            if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), rd_tab[i], 1'b0}) begin
                miscompares++;
                $display("FAIL unmapped_no_side_effect[%h]: got data=%h err=%b lat=%0d, want %h 0 %0d",
                         ra_tab[i], d, e, lat, rd_tab[i], RD_LAT);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic ok, e, rs, ra, va, rdy_b;
        logic [7:0]  lat;
        logic [31:0] d;
        cmd_vld = 1'b1;
        rw      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr   = 16'h0010 + 16'(i);
            data_w = 32'h0B0B_0000 + 32'(i);
            rdy_b  = cmd_rdy;
            tick();
            vectors++;
            if ({rdy_b, wr_ack, err} !== 3'b110) begin
                miscompares++;
                $display("FAIL b2b_wr[%0d]: got rdy=%b ack=%b err=%b, want 1 1 0", i, rdy_b, wr_ack, err);
            end
        end
        rw    = 1'b0;
        addr  = 16'h0013;
        rdy_b = cmd_rdy;
        tick();
        cmd_vld = 1'b0;
        collect_rd(lat, d, e, rs, ra, va);
        vectors++;
        if ({rdy_b, lat, d, e, rs, ra} !== {1'b1, 8'(RD_LAT), 32'h0B0B_0003, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL raw_same_entry: got rdy=%b lat=%0d data=%h err=%b rdy_in_wait=%b rdy_after=%b, want 1 %0d 0b0b0003 0 0 1",
                     rdy_b, lat, d, e, rs, ra, RD_LAT);
        end
        do_read(16'h0010, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'h0B0B_0000, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_rd_0010: got ok=%b lat=%0d data=%h err=%b, want 1 %0d 0b0b0000 0", ok, lat, d, e, RD_LAT);
        end
    endtask

    task automatic test_reset_midop;
        int unsigned cnt;
        logic ok, ack, e, rs, ra, va, early, vany, vld_seen;
        logic [7:0]  lat;
        logic [31:0] d;
        do_write(16'h0009, 32'hDEAD_BEEF, ok, ack, e);
        do_read(16'h0009, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'hDEAD_BEEF, 1'b0}) begin
            miscompares++;
            $display("FAIL midop_pre_rd: got ok=%b lat=%0d data=%h err=%b, want 1 %0d deadbeef 0", ok, lat, d, e, RD_LAT);
        end
        issue(1'b0, 16'h0009, 32'h0, ok);
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({ok, rd_vld, cmd_rdy, init_done, err, data_r} !== {1'b1, 4'b0000, 32'h0}) begin
            miscompares++;
            $display("FAIL midop_async_reset: got ok=%b vld=%b rdy=%b done=%b err=%b data=%h, want 1 0 0 0 0 00000000",
                     ok, rd_vld, cmd_rdy, init_done, err, data_r);
        end
        vld_seen = 1'b0;
        repeat (4) begin
            tick();
            if (rd_vld !== 1'b0) vld_seen = 1'b1;
        end
        reset_n = 1'b1;
        wait_sweep(cnt, early, vany);
        vectors++;
        if ((cnt !== TBL_DEPTH) || (early !== 1'b0) || (vld_seen !== 1'b0) || (vany !== 1'b0)) begin
            miscompares++;
            $display("FAIL midop_resweep: got busy_cycles=%0d early_done=%b vld_in_reset=%b vld_in_sweep=%b, want %0d 0 0 0",
                     cnt, early, vld_seen, vany, TBL_DEPTH);
        end
        do_read(16'h0009, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL midop_cleared: got ok=%b lat=%0d data=%h err=%b, want 1 %0d 00000000 0", ok, lat, d, e, RD_LAT);
        end
        do_read(16'h1003, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL midop_reg_reset: got ok=%b lat=%0d data=%h err=%b, want 1 %0d 00000000 0", ok, lat, d, e, RD_LAT);
        end
    endtask

`ifdef PIO_REGTBL_PARITY_EN
    task automatic test_parity;
        logic ok, ack, e, rs, ra, va;
        logic [7:0]  lat;
        logic [31:0] d;
        do_write(16'h0007, 32'h0000_0001, ok, ack, e);
        dut.u_ram.par_mem[7] = ~dut.u_ram.par_mem[7];
        do_read(16'h0007, ok, lat, d, e, rs, ra, va);
        vectors++;
        if ({ok, lat, d, e} !== {1'b1, 8'(RD_LAT), 32'h0000_0001, 1'b1}) begin
            miscompares++;
            $display("FAIL parity_flip: got ok=%b lat=%0d data=%h err=%b, want 1 %0d 00000001 1", ok, lat, d, e, RD_LAT);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_table();
        test_registers();
        test_unmapped();
        test_back_to_back();
        test_reset_midop();
`ifdef PIO_REGTBL_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
